grant_lock_frontend: RTL and testbench

Request front-end sitting directly upstream of the 4-requester fixed-priority arbiter. It collects one-cycle request pulses from four clients into per-client pending counters, drives the arbiter's `REQ` vector, and consumes the arbiter's `GNT`. Once a grant is accepted, it locks ownership for a fixed-length burst by masking `REQ` to the owner only. It then releases the bus for one cycle so the arbiter re-evaluates.

---
 rtl/grant_lock_frontend.sv | 137 +++++++++++++
 tb/tb_grant_lock_frontend.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grant_lock_frontend.sv
// Request front-end for the 4-way fixed-priority arbiter.
// Counts request strobes, exposes REQ, and locks a granted owner for one burst.
module grant_lock_frontend #(
    parameter int N         = 4,
    parameter int CNT_W     = 2,
    parameter int BURST_LEN = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req_pulse,
    output logic [N-1:0] REQ,
    input  logic [N-1:0] GNT,
    output logic [N-1:0] owner,
    output logic         beat_valid,
    output logic         beat_last,
    output logic [N-1:0] pend_ovf,
    output logic         gnt_err
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] PMAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     owner_q, owner_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0] pend_q [N];
    logic [CNT_W-1:0] pend_d [N];
    logic [N-1:0]     pend_nz;
    logic [N-1:0]     dec;
    logic [N-1:0]     ovf_d;
    logic             gnt_onehot;
    logic             accept;
    logic             err_d;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pend_nz[i] = (pend_q[i] != '0);
        end
    end

    // Outputs depend only on registered state.
    always_comb begin
        REQ        = '0;
        owner      = '0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        unique case (state_q)
            IDLE: REQ = pend_nz;
            BURST: begin
                REQ        = owner_q;
                owner      = owner_q;
                beat_valid = 1'b1;
                beat_last  = (beat_q == LAST);
            end
            default: ;
        endcase
    end

    always_comb begin
        gnt_onehot = (GNT != '0) && ((GNT & (GNT - N'(1))) == '0);
        accept     = (state_q == IDLE) && gnt_onehot && ((GNT & pend_nz) != '0);
        err_d      = (state_q == IDLE) && (GNT != '0) && !accept;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BURST;
                    owner_d = GNT;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (beat_last) begin
                    state_d = RELEASE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A strobe and a burst completion in the same cycle cancel out.
    always_comb begin
        dec = beat_last ? owner_q : '0;
        for (int i = 0; i < N; i++) begin
            pend_d[i] = pend_q[i];
            ovf_d[i]  = 1'b0;
            unique case (1'b1)
                req_pulse[i] && !dec[i]: begin
                    if (pend_q[i] == PMAX) begin
                        ovf_d[i] = 1'b1;
                    end else begin
                        pend_d[i] = pend_q[i] + CNT_W'(1);
                    end
                end
                dec[i] && !req_pulse[i]: pend_d[i] = pend_q[i] - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            beat_q   <= '0;
            pend_ovf <= '0;
            gnt_err  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            beat_q   <= beat_d;
            pend_ovf <= ovf_d;
            gnt_err  <= err_d;
            for (int i = 0; i < N; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

endmodule

// File: tb/tb_grant_lock_frontend.sv
// Randomised and directed bench for grant_lock_frontend.
// Outputs are compared every cycle against a counter/phase model.
module tb_grant_lock_frontend;

    localparam int BL = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req_pulse = '0;
    logic [3:0] REQ;
    logic [3:0] GNT = '0;
    logic [3:0] owner;
    logic       beat_valid;
    logic       beat_last;
    logic [3:0] pend_ovf;
    logic       gnt_err;

    int n_checks = 0;
    int n_fail = 0;

    int         m_pend [4];
    bit         m_burst;
    bit         m_rel;
    int         m_own;
    int         m_beat;
    logic [3:0] m_ovf;
    bit         m_err;

    grant_lock_frontend #(.N(4), .CNT_W(2), .BURST_LEN(BL)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_pulse(req_pulse),
        .REQ(REQ),
        .GNT(GNT),
        .owner(owner),
        .beat_valid(beat_valid),
        .beat_last(beat_last),
        .pend_ovf(pend_ovf),
        .gnt_err(gnt_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_req();
        logic [3:0] r;
        r = '0;
        if (m_burst) r = 4'(1 << m_own);
        else if (!m_rel) begin
            for (int i = 0; i < 4; i++) r[i] = (m_pend[i] != 0);
        end
        return r;
    endfunction

    function automatic logic [14:0] expv();
        logic [3:0] o;
        o = m_burst ? 4'(1 << m_own) : 4'b0;
        return {m_req(), o, m_burst, m_burst && (m_beat == BL - 1),
                m_ovf, m_err};
    endfunction

    function automatic logic [14:0] obsv();
        return {REQ, owner, beat_valid, beat_last, pend_ovf, gnt_err};
    endfunction

    function automatic logic [3:0] arb(input logic [3:0] r);
        return r & (~r + 4'd1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
        m_burst = 0;
        m_rel = 0;
        m_own = 0;
        m_beat = 0;
        m_ovf = '0;
        m_err = 0;
    endtask

    task automatic model_edge(input logic [3:0] rp, input logic [3:0] g);
        logic [3:0] r;
        bit last, idle;
        int p;
        r = m_req();
        idle = !m_burst && !m_rel;
        last = m_burst && (m_beat == BL - 1);
        for (int i = 0; i < 4; i++) begin
            p = m_pend[i] + int'(rp[i]) - ((last && m_own == i) ? 1 : 0);
            m_ovf[i] = (p > 3);
            m_pend[i] = (p > 3) ? 3 : p;
        end
        m_err = idle && (g != 0) && !(($countones(g) == 1) && ((g & r) != 0));
        if (m_burst) begin
            if (last) begin
                m_burst = 0;
                m_rel = 1;
            end else begin
                m_beat++;
            end
        end else if (m_rel) begin
            m_rel = 0;
        end else if (($countones(g) == 1) && ((g & r) != 0)) begin
            m_burst = 1;
            m_beat = 0;
            for (int i = 0; i < 4; i++) if (g[i]) m_own = i;
        end
    endtask

    task automatic tick(input logic [3:0] rp, input logic [3:0] g);
        req_pulse = rp;
        GNT = g;
        @(posedge clk);
        model_edge(rp, g);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_pulse = '0;
        GNT = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        tick(4'b0, 4'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obsv() !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", obsv());
        end
    endtask

    task automatic test_single();
        do_reset();
        tick(4'b1000, 4'b0);
        n_checks++;
        if (REQ !== 4'b1000) begin
            n_fail++;
            $display("FAIL single_req: got %b expected 1000", REQ);
        end
        tick(4'b0, 4'b1000);
        for (int c = 0; c < BL + 2; c++) begin
            n_checks++;
            if (obsv() !== expv()) begin
                n_fail++;
                $display("FAIL single_burst c%0d: got %h expected %h",
                         c, obsv(), expv());
            end
            tick(4'b0, 4'b0);
        end
        n_checks++;
        if (REQ !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_after: got %b expected 0000", REQ);
        end
    endtask

    task automatic test_masking();
        do_reset();
        tick(4'b0010, 4'b0);
        tick(4'b0, 4'b0010);
        tick(4'b1111, 4'b0);
        for (int c = 0; c < BL + 1; c++) begin
            n_checks++;
            if (obsv() !== expv()) begin
                n_fail++;
                $display("FAIL mask c%0d: got %h expected %h",
                         c, obsv(), expv());
            end
            tick(4'b0, 4'b0);
        end
        n_checks++;
        if (REQ !== 4'b1111) begin
            n_fail++;
            $display("FAIL mask_idle_req: got %b expected 1111", REQ);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (4) tick(4'b0100, 4'b0);
        n_checks++;
        if (pend_ovf !== 4'b0100) begin
            n_fail++;
            $display("FAIL sat_ovf: got %b expected 0100", pend_ovf);
        end
        tick(4'b0, 4'b0100);
        n_checks++;
        if (pend_ovf !== 4'b0000) begin
            n_fail++;
            $display("FAIL sat_ovf_len: got %b expected 0000", pend_ovf);
        end
        for (int c = 0; c < BL && !beat_last; c++) tick(4'b0, 4'b0);
        tick(4'b0100, 4'b0);
        n_checks++;
        if (obsv() !== expv() || pend_ovf !== 4'b0) begin
            n_fail++;
            $display("FAIL sat_cancel: got %h expected %h", obsv(), expv());
        end
        tick(4'b0, 4'b0);
        // Count still 3: three more bursts before REQ[2] drops.
        for (int c = 0; c < 3 * (BL + 2) + 2; c++) begin
            n_checks++;
            if (obsv() !== expv()) begin
                n_fail++;
                $display("FAIL sat_drain c%0d: got %h expected %h",
                         c, obsv(), expv());
            end
            tick(4'b0, arb(m_req()));
        end
    endtask

    task automatic test_illegal_grant();
        do_reset();
        tick(4'b0100, 4'b0);
        tick(4'b0, 4'b0110);
        n_checks++;
        if (gnt_err !== 1'b1 || owner !== 4'b0 || beat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_multi: got err=%b owner=%b bv=%b expected 1/0000/0",
                     gnt_err, owner, beat_valid);
        end
        tick(4'b0, 4'b1000);
        n_checks++;
        if (gnt_err !== 1'b1 || owner !== 4'b0 || REQ !== 4'b0100) begin
            n_fail++;
            $display("FAIL illegal_unbacked: got err=%b owner=%b req=%b expected 1/0000/0100",
                     gnt_err, owner, REQ);
        end
        tick(4'b0, 4'b0);
        n_checks++;
        if (obsv() !== expv()) begin
            n_fail++;
            $display("FAIL illegal_quiet: got %h expected %h", obsv(), expv());
        end
    endtask

    task automatic test_back_to_back();
        int lasts [$];
        do_reset();
        tick(4'b1000, 4'b0);
        tick(4'b1000, 4'b0);
        for (int c = 0; c < 2 * (BL + 2) + 3; c++) begin
            n_checks++;
            if (obsv() !== expv()) begin
                n_fail++;
                $display("FAIL b2b c%0d: got %h expected %h",
                         c, obsv(), expv());
            end
            if (beat_last) lasts.push_back(c);
            tick(4'b0, arb(m_req()));
        end
        n_checks++;
        if (lasts.size() != 2 || REQ !== 4'b0) begin
            n_fail++;
            $display("FAIL b2b_count: got bursts=%0d req=%b expected 2/0000",
                     lasts.size(), REQ);
        end else begin
            n_checks++;
            if (lasts[1] - lasts[0] != BL + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d expected %0d",
                         lasts[1] - lasts[0], BL + 2);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        tick(4'b0001, 4'b0);
        tick(4'b0, 4'b0001);
        tick(4'b0, 4'b0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obsv() !== 15'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got %h expected 0", obsv());
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(4'b0, 4'b0001);
            n_checks++;
            if (obsv() !== expv() || REQ !== 4'b0) begin
                n_fail++;
                $display("FAIL rst_after c%0d: got %h expected %h",
                         c, obsv(), expv());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] rp, g;
        int sel;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rp = 4'($urandom) & 4'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 6) g = arb(m_req());
            else if (sel < 8) g = 4'($urandom);
            else g = 4'b0;
            tick(rp, g);
            n_checks++;
            if (obsv() !== expv()) begin
                n_fail++;
                $display("FAIL random c%0d: got %h expected %h",
                         c, obsv(), expv());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_masking();
        test_saturation();
        test_illegal_grant();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
